adc_chan_align: RTL and testbench
=================================

Name: adc_chan_align

Overview:
- Multi-channel ADC input conditioner for the LVDS front end.
- Each channel is captured in an IOB register, converted from offset binary to two's complement, and delayed by a per-channel programmable tap (0..DEPTH-1 samples).
- A per-channel signed offset is then added, with optional saturation.
- Generalises the single-channel 13-bit converter: N channels, parametrised width and depth, tap-change settling FSM, valid flag, overflow flags.

Parameters:
- WIDTH, 13, ADC sample width (offset binary in, two's complement internally).
- NCH, 2, number of channels.
- DEPTH, 32, delay-line depth; power of 2, ≥4.
- TAPW, $clog2(DEPTH), tap field width (localparam-derived, not overridable).
- OUTW, WIDTH+1, output width; legal range WIDTH..WIDTH+1; OUTW=WIDTH enables saturation.

Ports:
- clk  in  1  sample clock.
- rst  in  1  reset; asynchronous, active-high.
- din  in  NCH*WIDTH  raw offset-binary samples; channel c at [c*WIDTH +: WIDTH].
- offset  in  NCH*WIDTH  signed per-channel offset, quasi-static.
- tap  in  NCH*TAPW  per-channel delay in samples.
- bypass  in  NCH  1 = channel skips delay line (equivalent to tap=0, no settling).
- freeze  in  1  stall delay-line writes/pointer.
- ovf_clr  in  1  clear sticky overflow flags.
- dout  out  NCH*OUTW  signed aligned, offset-corrected samples.
- dout_vld  out  1  dout is valid.
- settling  out  1  FILL or SETTLE state active.
- ovf  out  NCH  sticky saturation flag per channel.

Behaviour:
- Reset values:
  - capture registers = 1<<(WIDTH-1) (midscale, converts to 0).
  - dout = 0, dout_vld = 0, settling = 1, ovf = 0.
  - wr_ptr = 0; FSM in FILL.
- Conversion: invert MSB (XOR with -2^(WIDTH-1)).
- Pipeline:
  - din is sampled at edge n into the capture register.
  - Convert/select register at n+1.
  - dout at n+2.
  - Net: dout reflects din presented before edge n at edge n+2+tap (tap forced to 0 when bypass[c]=1).
- Delay line: one circular buffer per channel (inferred RAM/SRL), shared wr_ptr.
  - Writes the converted sample and increments mod DEPTH each cycle when freeze=0.
  - Read address = wr_ptr - tap (mod DEPTH); tap=0 reads the current sample (write-first or explicit bypass mux).
- freeze=1:
  - wr_ptr and buffer hold.
  - Select stage holds its last value; dout_vld=0 for every cycle whose select stage was frozen.
  - FSM counters pause.
- Offset add:
  - sum = conv + offset, computed in WIDTH+1 bits (cannot overflow).
  - If OUTW=WIDTH+1: dout = sum.
  - If OUTW=WIDTH: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set ovf[c] on any clamp.
- ovf: sticky until ovf_clr. If set and clear occur in the same cycle, set wins.
- FSM (states FILL, RUN, SETTLE):
  - FILL: after reset, count DEPTH written samples, then go to RUN.
  - RUN: dout_vld=1 (subject to freeze). Any change in registered tap or bypass → SETTLE with counter = DEPTH-1.
  - SETTLE: dout_vld=0, settling=1. A further tap/bypass change reloads the counter. Counter reaching 0 → RUN.
  - While dout_vld=0, dout continues to update (not held); consumers must qualify with dout_vld.
- rst asserted mid-operation: immediate return to the reset values above. Buffer contents are not cleared; FILL masks them.
- offset changes take effect two cycles later and do not trigger SETTLE.

Optional Feature:
- ADC_IN_PIPE_EN: when defined, adds one extra register between capture and conversion (reset to midscale) for timing closure.
  - Latency becomes n+3+tap.
  - FILL length is unchanged.
- When undefined: latency as above.

Decomposition:
- Shared package adc_pkg holds:
  - midscale/BITFLIP constant function of WIDTH.
  - FSM state enum (FILL, RUN, SETTLE).
  - Channel slice helper functions.
- One natural sub-module: adc_dly_line (single channel: circular buffer + read mux), instantiated NCH times.
- Top level holds capture registers, shared wr_ptr, FSM, offset/saturation, ovf.

Test Plan:
- Reset → settling=1, dout_vld=0 for 32 cycles, then dout_vld=1. Midscale din 13'h1000 gives dout=0 on both channels.
- Conversion, tap=0, offset=0: din 13'h0000 → -4096; 13'h1FFF → 4095. Each appears exactly 2 cycles after sampling.
- ch0 tap=5, ch1 bypass:
  - Impulse 13'h1400 on both channels.
  - ch1 dout=1024 at edge n+2; ch0 dout=1024 at edge n+7.
  - Tap write triggers a 32-cycle SETTLE with dout_vld=0.
- OUTW=13, offset=+10, din 13'h1FFF → dout=4095, ovf[0]=1 and sticky. ovf_clr → 0. Same test with OUTW=14 → dout=4105, no ovf.
- freeze high 4 cycles in RUN → dout_vld low for 4 aligned cycles; after release, the delay alignment is preserved (tap=5 impulse still exactly 5 samples late).
- Assert rst during SETTLE → outputs at reset values immediately (asynchronously); FILL repeats for 32 cycles.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the multi-channel ADC aligner.
// FSM states, midscale constant and channel slice helpers.
package adc_pkg;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    SETTLE
  } state_t;

  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned lsb(input int unsigned c,
                                      input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/adc_dly_line.sv
// Single-channel circular delay line with tap-0 passthrough.
// Shares its write pointer with the other channels.
module adc_dly_line
  import adc_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 32,
  localparam int TAPW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [TAPW-1:0]  i_wr_ptr,
  input  logic [TAPW-1:0]  i_tap,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [TAPW-1:0]  w_rd_addr;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_ptr] <= i_din;
  end

  assign w_rd_addr = i_wr_ptr - i_tap;

  // tap 0 must see the sample being written this cycle
  assign o_dout = (i_tap == '0) ? i_din : r_mem[w_rd_addr];

endmodule

// File: rtl/adc_chan_align.sv
// ADC channel aligner: capture, convert, per-channel delay, offset/sat.
// Define ADC_IN_PIPE_EN for an extra register ahead of conversion.
module adc_chan_align
  import adc_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int NCH   = 2,
  parameter int DEPTH = 32,
  parameter int OUTW  = WIDTH + 1,
  localparam int TAPW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [NCH*WIDTH-1:0] offset,
  input  logic [NCH*TAPW-1:0]  tap,
  input  logic [NCH-1:0]       bypass,
  input  logic                freeze,
  input  logic                ovf_clr,
  output logic [NCH*OUTW-1:0]  dout,
  output logic                dout_vld,
  output logic                settling,
  output logic [NCH-1:0]       ovf
);

  localparam logic [WIDTH-1:0] MID  = WIDTH'(midscale(WIDTH));
  localparam logic [TAPW-1:0]  CMAX = TAPW'(DEPTH - 1);

  state_t               r_state, w_state_nx;
  logic [TAPW-1:0]      r_cnt, w_cnt_nx;
  logic [TAPW-1:0]      r_wr_ptr;
  logic [NCH*TAPW-1:0]  r_tap;
  logic [NCH-1:0]       r_byp;
  logic [NCH*WIDTH-1:0] r_cap, r_off, w_src;
  logic                 r_sel_vld, r_vld;
  logic [NCH-1:0]       r_ovf, w_clamp;
  logic                 w_chg;

`ifdef ADC_IN_PIPE_EN
  logic [NCH*WIDTH-1:0] r_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pipe <= {NCH{MID}};
    else     r_pipe <= r_cap;
  end

  assign w_src = r_pipe;
`else
  assign w_src = r_cap;
`endif

  assign w_chg = (tap != r_tap) || (bypass != r_byp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap     <= {NCH{MID}};
      r_off     <= '0;
      r_tap     <= '0;
      r_byp     <= '0;
      r_wr_ptr  <= '0;
      r_state   <= FILL;
      r_cnt     <= '0;
      r_sel_vld <= 1'b0;
      r_vld     <= 1'b0;
      r_ovf     <= '0;
    end else begin
      r_cap     <= din;
      r_off     <= offset;
      r_tap     <= tap;
      r_byp     <= bypass;
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      if (!freeze) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_sel_vld <= !freeze && (w_state_nx == RUN);
      r_vld     <= r_sel_vld;
      r_ovf     <= (r_ovf & ~{NCH{ovf_clr}}) | w_clamp;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      FILL: begin
        if (!freeze) begin
          if (r_cnt == CMAX) begin
            w_state_nx = RUN;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (w_chg) begin
          w_state_nx = SETTLE;
          w_cnt_nx   = CMAX;
        end
      end
      SETTLE: begin
        if (w_chg) begin
          w_cnt_nx = CMAX;
        end else if (!freeze) begin
          if (r_cnt == '0) w_state_nx = RUN;
          else             w_cnt_nx = r_cnt - 1'b1;
        end
      end
      default: w_state_nx = FILL;
    endcase
  end

  assign dout_vld = r_vld;
  assign settling = (r_state != RUN);
  assign ovf      = r_ovf;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0]      w_conv, w_dly, w_o;
    logic [TAPW-1:0]       w_etap;
    logic [WIDTH-1:0]      r_sel;
    logic signed [WIDTH:0] w_sum;
    logic [OUTW-1:0]       w_out, r_dout;

    assign w_conv = w_src[lsb(c, WIDTH) +: WIDTH] ^ MID;
    assign w_etap = r_byp[c] ? '0 : r_tap[lsb(c, TAPW) +: TAPW];
    assign w_o    = r_off[lsb(c, WIDTH) +: WIDTH];

    adc_dly_line #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_dly (
      .clk      (clk),
      .i_we     (~freeze),
      .i_wr_ptr (r_wr_ptr),
      .i_tap    (w_etap),
      .i_din    (w_conv),
      .o_dout   (w_dly)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sel  <= '0;
        r_dout <= '0;
      end else begin
        if (!freeze) r_sel <= w_dly;
        r_dout <= w_out;
      end
    end

    assign w_sum = $signed({r_sel[WIDTH-1], r_sel})
                 + $signed({w_o[WIDTH-1], w_o});

    if (OUTW == WIDTH) begin : g_sat
      // top two sum bits disagree only when the narrow result overflows
      assign w_clamp[c] = w_sum[WIDTH] ^ w_sum[WIDTH-1];
      assign w_out = w_clamp[c]
                   ? {w_sum[WIDTH], {(WIDTH-1){~w_sum[WIDTH]}}}
                   : w_sum[WIDTH-1:0];
    end else begin : g_wide
      assign w_clamp[c] = 1'b0;
      assign w_out      = w_sum;
    end

    assign dout[c*OUTW +: OUTW] = r_dout;
  end

endmodule

// File: tb/tb_adc_chan_align.sv
// Directed bench for adc_chan_align (wide and saturating builds).
// Hand-computed expectations for fill, conversion, taps, sat, freeze.
module tb_adc_chan_align;

  localparam logic [12:0] MIDS = 13'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [25:0] din = {MIDS, MIDS};
  logic [25:0] offset = '0;
  logic [9:0]  tap = '0;
  logic [1:0]  bypass = '0;
  logic        freeze = 1'b0;
  logic        ovf_clr = 1'b0;

  wire [27:0] dout;
  wire        dout_vld, settling;
  wire [1:0]  ovf;
  wire [25:0] s_dout;
  wire        s_vld, s_set;
  wire [1:0]  s_ovf;

  wire signed [13:0] d0 = dout[13:0];
  wire signed [13:0] d1 = dout[27:14];
  wire signed [12:0] s0 = s_dout[12:0];
  wire signed [12:0] s1 = s_dout[25:13];

  int n_vec = 0;
  int n_err = 0;

  adc_chan_align u_dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .offset   (offset),
    .tap      (tap),
    .bypass   (bypass),
    .freeze   (freeze),
    .ovf_clr  (ovf_clr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .settling (settling),
    .ovf      (ovf)
  );

  adc_chan_align #(.OUTW(13)) u_sat (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .offset   (offset),
    .tap      (tap),
    .bypass   (bypass),
    .freeze   (freeze),
    .ovf_clr  (ovf_clr),
    .dout     (s_dout),
    .dout_vld (s_vld),
    .settling (s_set),
    .ovf      (s_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ev, es;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (dout !== '0 || dout_vld !== 1'b0 || settling !== 1'b1
        || ovf !== 2'b00 || s_dout !== '0) begin
      n_err++;
      $display("FAIL reset_vals dout=%h vld=%b set=%b ovf=%b want 0/0/1/0",
               dout, dout_vld, settling, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      ev = (i == 33);
      es = (i < 32);
      n_vec++;
      if (dout_vld !== ev || settling !== es || s_vld !== ev) begin
        n_err++;
        $display("FAIL fill edge %0d vld=%b set=%b want vld=%b set=%b",
                 i, dout_vld, settling, ev, es);
      end
    end
    n_vec++;
    if (d0 !== 14'sd0 || d1 !== 14'sd0) begin
      n_err++;
      $display("FAIL midscale d0=%0d d1=%0d want 0", d0, d1);
    end
  endtask

  task automatic test_convert();
    logic [12:0]       v;
    logic signed [13:0] e, ek;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 13'h0000 : 13'h1FFF;
      e = (k == 0) ? -14'sd4096 : 14'sd4095;
      din = {v, v};
      tick();
      din = {MIDS, MIDS};
      for (int j = 1; j <= 3; j++) begin
        tick();
        ek = (j == 2) ? e : 14'sd0;
        n_vec++;
        if (d0 !== ek || d1 !== ek) begin
          n_err++;
          $display("FAIL convert v=%h n+%0d d0=%0d d1=%0d want %0d",
                   v, j, d0, d1, ek);
        end
      end
    end
  endtask

  task automatic test_tap();
    logic es, ev;
    logic signed [13:0] e0, e1;
    tap = {5'd0, 5'd5};
    bypass = 2'b10;
    tick();
    n_vec++;
    if (settling !== 1'b1) begin
      n_err++;
      $display("FAIL tap_settle_enter set=%b want 1", settling);
    end
    for (int i = 1; i <= 33; i++) begin
      tick();
      ev = (i == 33);
      es = (i < 32);
      n_vec++;
      if (dout_vld !== ev || settling !== es) begin
        n_err++;
        $display("FAIL settle edge %0d vld=%b set=%b want vld=%b set=%b",
                 i, dout_vld, settling, ev, es);
      end
    end
    din = {13'h1400, 13'h1400};
    tick();
    din = {MIDS, MIDS};
    for (int k = 1; k <= 8; k++) begin
      tick();
      e0 = (k == 7) ? 14'sd1024 : 14'sd0;
      e1 = (k == 2) ? 14'sd1024 : 14'sd0;
      n_vec++;
      if (d0 !== e0 || d1 !== e1 || dout_vld !== 1'b1) begin
        n_err++;
        $display("FAIL tap_impulse n+%0d d0=%0d d1=%0d vld=%b want %0d %0d 1",
                 k, d0, d1, dout_vld, e0, e1);
      end
    end
  endtask

  task automatic test_saturation();
    offset = {13'd10, 13'd10};
    din = {13'h1FFF, 13'h1FFF};
    repeat (10) tick();
    n_vec++;
    if (d0 !== 14'sd4105 || d1 !== 14'sd4105 || ovf !== 2'b00) begin
      n_err++;
      $display("FAIL wide_pos d0=%0d d1=%0d ovf=%b want 4105 4105 00",
               d0, d1, ovf);
    end
    n_vec++;
    if (s0 !== 13'sd4095 || s1 !== 13'sd4095 || s_ovf !== 2'b11) begin
      n_err++;
      $display("FAIL sat_pos s0=%0d s1=%0d ovf=%b want 4095 4095 11",
               s0, s1, s_ovf);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_vec++;
    if (s_ovf !== 2'b11) begin
      n_err++;
      $display("FAIL ovf_set_wins ovf=%b want 11", s_ovf);
    end
    din = {MIDS, MIDS};
    repeat (10) tick();
    n_vec++;
    if (s0 !== 13'sd10 || s1 !== 13'sd10 || s_ovf !== 2'b11) begin
      n_err++;
      $display("FAIL ovf_sticky s0=%0d s1=%0d ovf=%b want 10 10 11",
               s0, s1, s_ovf);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_vec++;
    if (s_ovf !== 2'b00) begin
      n_err++;
      $display("FAIL ovf_clear ovf=%b want 00", s_ovf);
    end
    offset = {13'h1FF6, 13'h1FF6};
    din = {13'h0000, 13'h0000};
    repeat (10) tick();
    n_vec++;
    if (d1 !== -14'sd4106 || s1 !== -13'sd4096 || s0 !== -13'sd4096
        || s_ovf !== 2'b11) begin
      n_err++;
      $display("FAIL sat_neg d1=%0d s0=%0d s1=%0d ovf=%b want -4106 -4096 -4096 11",
               d1, s0, s1, s_ovf);
    end
    offset = '0;
    din = {MIDS, MIDS};
    repeat (10) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_freeze();
    logic ev;
    logic signed [13:0] e0, e1;
    for (int i = 0; i <= 5; i++) begin
      freeze = (i < 4);
      tick();
      ev = (i == 0 || i == 5);
      n_vec++;
      if (dout_vld !== ev || settling !== 1'b0) begin
        n_err++;
        $display("FAIL freeze step %0d vld=%b set=%b want vld=%b set=0",
                 i, dout_vld, settling, ev);
      end
    end
    freeze = 1'b0;
    din = {13'h1400, 13'h1400};
    tick();
    din = {MIDS, MIDS};
    for (int k = 1; k <= 8; k++) begin
      tick();
      e0 = (k == 7) ? 14'sd1024 : 14'sd0;
      e1 = (k == 2) ? 14'sd1024 : 14'sd0;
      n_vec++;
      if (d0 !== e0 || d1 !== e1) begin
        n_err++;
        $display("FAIL freeze_align n+%0d d0=%0d d1=%0d want %0d %0d",
                 k, d0, d1, e0, e1);
      end
    end
  endtask

  task automatic test_rst_settle();
    logic ev;
    offset = {13'd7, 13'd7};
    tap = {5'd0, 5'd3};
    tick();
    repeat (5) tick();
    n_vec++;
    if (settling !== 1'b1 || d1 !== 14'sd7 || s1 !== 13'sd7) begin
      n_err++;
      $display("FAIL pre_rst set=%b d1=%0d s1=%0d want 1 7 7",
               settling, d1, s1);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (dout !== '0 || s_dout !== '0 || dout_vld !== 1'b0
        || settling !== 1'b1 || ovf !== 2'b00 || s_ovf !== 2'b00) begin
      n_err++;
      $display("FAIL async_rst dout=%h sdout=%h vld=%b set=%b want 0 0 0 1",
               dout, s_dout, dout_vld, settling);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      ev = (i == 33);
      n_vec++;
      if (dout_vld !== ev) begin
        n_err++;
        $display("FAIL refill edge %0d vld=%b want %b", i, dout_vld, ev);
      end
    end
    n_vec++;
    if (d0 !== 14'sd7 || d1 !== 14'sd7) begin
      n_err++;
      $display("FAIL refill_data d0=%0d d1=%0d want 7 7", d0, d1);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_tap();
    test_saturation();
    test_freeze();
    test_rst_settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
